// File: rtl/multi_blink.sv
// -----------------------------------------------------------------------------
// multi_blink
// Multi-channel programmable blink / PWM generator. Each channel owns a free
// running counter plus an active {period, high} pair. Host writes land in a
// per-channel shadow pair and reach the active pair only at an apply point:
// the channel's own wrap, a global i_Sync restart, or while the channel is
// disabled or parked at period 0. The waveform therefore never glitches in
// the middle of a period.
//
// Ports
//   i_Clk        board clock, rising edge
//   i_Rst_n      asynchronous active-low reset
//   i_Enable     per-channel run enable (level)
//   i_Sync       one-cycle pulse, restarts every enabled channel at phase 0
//   i_Wr_En      write strobe (one write per cycle, always accepted)
//   i_Wr_Ch      channel to write; values >= CHANNELS are ignored
//   i_Wr_Period  new period in cycles (0 parks the channel off)
//   i_Wr_High    new high time in cycles
//   o_LED        registered channel outputs
//   o_Wrap       one-cycle pulse on the first cycle of each new period
//   o_Pending    shadow write waiting to be applied
// -----------------------------------------------------------------------------
module multi_blink #(
    parameter int CHANNELS     = 4,
    parameter int CNT_WIDTH    = 25,
    parameter int RESET_PERIOD = 25000000,
    parameter int RESET_HIGH   = 12500000,
    parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic [CHANNELS-1:0]  i_Enable,
    input  logic                 i_Sync,
    input  logic                 i_Wr_En,
    input  logic [CH_W-1:0]      i_Wr_Ch,
    input  logic [CNT_WIDTH-1:0] i_Wr_Period,
    input  logic [CNT_WIDTH-1:0] i_Wr_High,
    output logic [CHANNELS-1:0]  o_LED,
    output logic [CHANNELS-1:0]  o_Wrap,
    output logic [CHANNELS-1:0]  o_Pending
);

    localparam logic [CNT_WIDTH-1:0] ZERO_C       = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] ONE_C        = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] RST_PERIOD_C = CNT_WIDTH'(RESET_PERIOD);
    localparam logic [CNT_WIDTH-1:0] RST_HIGH_C   = CNT_WIDTH'(RESET_HIGH);

    genvar g;
    for (g = 0; g < CHANNELS; g = g + 1) begin : g_ch

        // Registered per-channel state
        logic [CNT_WIDTH-1:0] cnt_r;
        logic [CNT_WIDTH-1:0] act_period_r;
        logic [CNT_WIDTH-1:0] act_high_r;
        logic [CNT_WIDTH-1:0] pend_period_r;
        logic [CNT_WIDTH-1:0] pend_high_r;
        logic                 pend_flag_r;
        logic                 led_r;
        logic                 wrap_r;

        // Next-state terms
        logic                 en_s;
        logic                 wr_hit_s;
        logic                 idle_s;
        logic                 at_end_s;
        logic                 restart_s;
        logic                 apply_s;
        logic [CNT_WIDTH-1:0] src_period_s;
        logic [CNT_WIDTH-1:0] src_high_s;
        logic [CNT_WIDTH-1:0] period_next_s;
        logic [CNT_WIDTH-1:0] high_next_s;
        logic [CNT_WIDTH-1:0] cnt_next_s;
        logic                 pend_flag_next_s;
        logic                 led_next_s;
        logic                 wrap_next_s;

        // Decide apply point, post-apply config, next counter and next outputs
        always_comb begin
            en_s             = i_Enable[g];
            wr_hit_s         = 1'b0;
            idle_s           = 1'b0;
            at_end_s         = 1'b0;
            restart_s        = 1'b0;
            apply_s          = 1'b0;
            src_period_s     = pend_period_r;
            src_high_s       = pend_high_r;
            period_next_s    = act_period_r;
            high_next_s      = act_high_r;
            cnt_next_s       = ZERO_C;
            pend_flag_next_s = pend_flag_r;
            led_next_s       = 1'b0;
            wrap_next_s      = 1'b0;

            // Channel index compare also filters out-of-range selects
            if (i_Wr_En && (i_Wr_Ch == CH_W'(g))) begin
                wr_hit_s = 1'b1;
            end else begin
                wr_hit_s = 1'b0;
            end

            idle_s    = (act_period_r == ZERO_C);
            at_end_s  = en_s && !idle_s && (cnt_r == (act_period_r - ONE_C));
            restart_s = at_end_s || i_Sync;
            // A parked (period 0) or disabled channel sits on the apply point
            apply_s   = restart_s || !en_s || idle_s;

            // A same-cycle write overrides the older shadow contents
            if (wr_hit_s) begin
                src_period_s = i_Wr_Period;
                src_high_s   = i_Wr_High;
            end else begin
                src_period_s = pend_period_r;
                src_high_s   = pend_high_r;
            end

            if (apply_s) begin
                period_next_s    = src_period_s;
                high_next_s      = src_high_s;
                pend_flag_next_s = 1'b0;
            end else if (wr_hit_s) begin
                period_next_s    = act_period_r;
                high_next_s      = act_high_r;
                pend_flag_next_s = 1'b1;
            end else begin
                period_next_s    = act_period_r;
                high_next_s      = act_high_r;
                pend_flag_next_s = pend_flag_r;
            end

            // Leaving period 0 starts the new pattern at phase 0 without a wrap
            if (!en_s || (period_next_s == ZERO_C) || idle_s || restart_s) begin
                cnt_next_s = ZERO_C;
            end else begin
                cnt_next_s = cnt_r + ONE_C;
            end

            if (en_s && (period_next_s != ZERO_C)) begin
                led_next_s  = (cnt_next_s < high_next_s);
                wrap_next_s = restart_s && (cnt_next_s == ZERO_C);
            end else begin
                led_next_s  = 1'b0;
                wrap_next_s = 1'b0;
            end
        end

        // Channel state registers with asynchronous reset to the boot pattern
        always_ff @(posedge i_Clk or negedge i_Rst_n) begin
            if (!i_Rst_n) begin
                cnt_r         <= ZERO_C;
                act_period_r  <= RST_PERIOD_C;
                act_high_r    <= RST_HIGH_C;
                pend_period_r <= RST_PERIOD_C;
                pend_high_r   <= RST_HIGH_C;
                pend_flag_r   <= 1'b0;
                led_r         <= 1'b0;
                wrap_r        <= 1'b0;
            end else begin
                cnt_r         <= cnt_next_s;
                act_period_r  <= period_next_s;
                act_high_r    <= high_next_s;
                pend_period_r <= src_period_s;
                pend_high_r   <= src_high_s;
                pend_flag_r   <= pend_flag_next_s;
                led_r         <= led_next_s;
                wrap_r        <= wrap_next_s;
            end
        end

        assign o_LED[g]     = led_r;
        assign o_Wrap[g]    = wrap_r;
        assign o_Pending[g] = pend_flag_r;
    end

endmodule
